// File: rtl/vc_lru_buffer.sv
// vc_lru_buffer: LRU victim cache between L1 and the next level, with its own dirty write-back path
module vc_lru_buffer #(
    parameter int entries    = 8,
    parameter int line_width = 256,
    parameter int addr_width = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [addr_width-1:0]     mem_address,
    input  logic [line_width-1:0]     mem_wdata,
    input  logic                      mem_dirty,
    output logic [line_width-1:0]     mem_rdata,
    output logic                      mem_rdirty,
    output logic                      mem_resp,
    output logic                      pmem_read,
    output logic                      pmem_write,
    output logic [addr_width-1:0]     pmem_address,
    output logic [line_width-1:0]     pmem_wdata,
    input  logic [line_width-1:0]     pmem_rdata,
    input  logic                      pmem_resp,
    output logic [$clog2(entries):0]  occupancy
);
    localparam int AW = $clog2(entries);
    localparam logic [AW-1:0] MAX_AGE = AW'(entries - 1);

    typedef enum logic [2:0] {IDLE, HIT, MISS, WB, RESP} state_t;

    state_t                  r_state, w_next;
    logic [entries-1:0]      r_valid, r_dirty;
    logic [addr_width-1:0]   r_addr [entries];
    logic [line_width-1:0]   r_data [entries];
    logic [AW-1:0]           r_age  [entries];
    logic [AW-1:0]           r_vic;
    logic [line_width-1:0]   r_rdata, r_pwdata;
    logic                    r_rdirty;
    logic [addr_width-1:0]   r_paddr;

    logic                    w_hit, w_free, w_wr, w_clr, w_wr_dirty;
    logic [AW-1:0]           w_hit_idx, w_free_idx, w_vic_idx, w_vic_age, w_wr_idx;

    assign mem_resp     = (r_state == HIT) || (r_state == RESP);
    assign pmem_read    = (r_state == MISS);
    assign pmem_write   = (r_state == WB);
    assign mem_rdata    = r_rdata;
    assign mem_rdirty   = r_rdirty;
    assign pmem_address = r_paddr;
    assign pmem_wdata   = r_pwdata;

    // Tag match, lowest free slot, oldest entry (first index wins ties) and valid count
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_vic_idx  = '0;
        w_vic_age  = r_age[0];
        occupancy  = '0;
        for (int i = 0; i < entries; i++) begin
            if (r_valid[i] && r_addr[i] == mem_address) begin
                w_hit     = 1'b1;
                w_hit_idx = AW'(i);
            end
            if (!r_valid[i] && !w_free) begin
                w_free     = 1'b1;
                w_free_idx = AW'(i);
            end
            if (r_age[i] > w_vic_age) begin
                w_vic_idx = AW'(i);
                w_vic_age = r_age[i];
            end
            occupancy = occupancy + {{AW{1'b0}}, r_valid[i]};
        end
    end

    // Next state plus the insert/invalidate strobes; a pending read always wins over a write
    always_comb begin
        w_next     = r_state;
        w_wr       = 1'b0;
        w_clr      = 1'b0;
        w_wr_idx   = (r_state == WB) ? r_vic : w_hit ? w_hit_idx : w_free ? w_free_idx : w_vic_idx;
        w_wr_dirty = mem_dirty | (w_hit & r_dirty[w_wr_idx]);
        case (r_state)
            IDLE: begin
                if (mem_read) begin
                    w_next = w_hit ? HIT : MISS;
                    w_clr  = w_hit;
                end else if (mem_write) begin
                    if (!w_hit && !w_free && r_dirty[w_vic_idx]) begin
                        w_next = WB;
                    end else begin
                        w_wr   = 1'b1;
                        w_next = RESP;
                    end
                end
            end
            MISS:    w_next = pmem_resp ? RESP : MISS;
            WB: begin
                w_wr   = pmem_resp;
                w_next = pmem_resp ? RESP : WB;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Entry array: invalidate on a read hit, fill and age on insert (ages saturate at the maximum)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int i = 0; i < entries; i++) r_age[i] <= '0;
        end else begin
            if (w_clr) r_valid[w_hit_idx] <= 1'b0;
            if (w_wr) begin
                for (int i = 0; i < entries; i++) begin
                    if (AW'(i) == w_wr_idx) begin
                        r_valid[i] <= 1'b1;
                        r_dirty[i] <= w_wr_dirty;
                        r_addr[i]  <= mem_address;
                        r_data[i]  <= mem_wdata;
                        r_age[i]   <= '0;
                    end else if (r_valid[i] && r_age[i] != MAX_AGE &&
                                 (!r_valid[w_wr_idx] || r_age[i] < r_age[w_wr_idx])) begin
                        r_age[i] <= r_age[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Output and lower-level operand registers, captured when a transaction starts or completes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rdirty <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_vic    <= '0;
        end else begin
            if (r_state == IDLE && mem_read && w_hit) begin
                r_rdata  <= r_data[w_hit_idx];
                r_rdirty <= r_dirty[w_hit_idx];
            end
            if (r_state == IDLE && mem_read && !w_hit) r_paddr <= mem_address;
            if (r_state == MISS && pmem_resp) begin
                r_rdata  <= pmem_rdata;
                r_rdirty <= 1'b0;
            end
            if (r_state == IDLE && w_next == WB) begin
                r_paddr  <= r_addr[w_vic_idx];
                r_pwdata <= r_data[w_vic_idx];
                r_vic    <= w_vic_idx;
            end
        end
    end
endmodule

// File: tb/tb_vc_lru_buffer.sv
// tb_vc_lru_buffer: directed and random checks of the victim buffer against an entry-level model
module tb_vc_lru_buffer;
    localparam int E  = 8;
    localparam int LW = 256;
    localparam int AW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           mem_read, mem_write, mem_dirty;
    logic [AW-1:0]  mem_address;
    logic [LW-1:0]  mem_wdata, mem_rdata, pmem_wdata, pmem_rdata;
    logic           mem_rdirty, mem_resp, pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0]  pmem_address;
    logic [3:0]     occupancy;

    int checks = 0;
    int errors = 0;

    bit            mv [E];
    bit            md [E];
    logic [AW-1:0] ma [E];
    logic [LW-1:0] mdat [E];
    int            mage [E];

    vc_lru_buffer #(.entries(E), .line_width(LW), .addr_width(AW)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_dirty(mem_dirty),
        .mem_rdata(mem_rdata), .mem_rdirty(mem_rdirty), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rline();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < E; i++) begin
            mv[i] = 0; md[i] = 0; mage[i] = 0;
        end
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < E; i++) n += mv[i];
        return n;
    endfunction

    function automatic void m_read(input logic [AW-1:0] a, input logic [LW-1:0] pd,
                                   output bit hit, output logic [LW-1:0] d, output bit dty);
        hit = 0; d = pd; dty = 0;
        for (int i = 0; i < E; i++)
            if (mv[i] && ma[i] == a) begin
                hit = 1; d = mdat[i]; dty = md[i]; mv[i] = 0;
            end
    endfunction

    function automatic void m_insert(input logic [AW-1:0] a, input logic [LW-1:0] wd, input bit dty,
                                     output bit wb, output logic [AW-1:0] wa, output logic [LW-1:0] wdat);
        int t = -1;
        wb = 0; wa = '0; wdat = '0;
        for (int i = 0; i < E; i++) if (mv[i] && ma[i] == a) t = i;
        if (t >= 0) begin
            for (int i = 0; i < E; i++) if (i != t && mv[i] && mage[i] < mage[t]) mage[i]++;
            md[t] = md[t] | dty;
        end else begin
            for (int i = 0; i < E; i++) if (!mv[i] && t < 0) t = i;
            if (t < 0) begin
                t = 0;
                for (int i = 1; i < E; i++) if (mage[i] > mage[t]) t = i;
                wb = md[t]; wa = ma[t]; wdat = mdat[t];
            end
            for (int i = 0; i < E; i++)
                if (i != t && mv[i]) mage[i] = (mage[i] + 1 > E - 1) ? E - 1 : mage[i] + 1;
            md[t] = dty;
        end
        mv[t] = 1; ma[t] = a; mdat[t] = wd; mage[t] = 0;
    endfunction

    // Plays the lower level: holds pmem_resp off for d cycles of an outstanding request
    task automatic wait_resp(input int d, input logic [LW-1:0] pd, output int lat, output int kind,
                             output int pcyc, output logic [AW-1:0] pa, output logic [LW-1:0] pw,
                             output bit stable, output logic [LW-1:0] rd, output logic rdy);
        lat = 0; kind = 0; pcyc = 0; pa = '0; pw = '0; stable = 1; rd = '0; rdy = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (mem_resp) begin
                lat = n; rd = mem_rdata; rdy = mem_rdirty; pmem_resp = 0;
                break;
            end
            pmem_resp = 0;
            if (pmem_read || pmem_write) begin
                if (pcyc == 0) begin
                    pa = pmem_address; pw = pmem_wdata;
                end else if (pa !== pmem_address || pw !== pmem_wdata) stable = 0;
                kind = kind | (pmem_read ? 1 : 0) | (pmem_write ? 2 : 0);
                pcyc++;
                if (pcyc == d + 1) begin
                    pmem_resp = 1; pmem_rdata = pd;
                end
            end
        end
    endtask

    task automatic after_resp(input string tag);
        @(posedge clk); #1;
        chk({tag, ".resp_one"}, LW'(mem_resp), LW'(0));
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int d, input string tag);
        logic [LW-1:0] pd, ed, rd, pw;
        logic [AW-1:0] pa;
        bit hit, edty, stable;
        logic rdy;
        int lat, kind, pcyc;
        pd = rline();
        m_read(a, pd, hit, ed, edty);
        mem_read = 1; mem_address = a;
        wait_resp(d, pd, lat, kind, pcyc, pa, pw, stable, rd, rdy);
        mem_read = 0;
        chk({tag, ".lat"}, LW'(lat), LW'(hit ? 1 : d + 2));
        chk({tag, ".pkind"}, LW'(kind), LW'(hit ? 0 : 1));
        if (!hit) begin
            chk({tag, ".paddr"}, LW'(pa), LW'(a));
            chk({tag, ".pcyc"}, LW'(pcyc), LW'(d + 1));
        end
        chk({tag, ".rdata"}, rd, ed);
        chk({tag, ".rdirty"}, LW'(rdy), LW'(edty));
        chk({tag, ".occ"}, LW'(occupancy), LW'(m_occ()));
        after_resp(tag);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] wd, input bit dty,
                            input int d, input string tag);
        logic [LW-1:0] ewd, rd, pw;
        logic [AW-1:0] ewa, pa;
        bit wb, stable;
        logic rdy;
        int lat, kind, pcyc;
        m_insert(a, wd, dty, wb, ewa, ewd);
        mem_write = 1; mem_address = a; mem_wdata = wd; mem_dirty = dty;
        wait_resp(d, '0, lat, kind, pcyc, pa, pw, stable, rd, rdy);
        mem_write = 0;
        chk({tag, ".lat"}, LW'(lat), LW'(wb ? d + 2 : 1));
        chk({tag, ".pkind"}, LW'(kind), LW'(wb ? 2 : 0));
        if (wb) begin
            chk({tag, ".wbaddr"}, LW'(pa), LW'(ewa));
            chk({tag, ".wbdata"}, pw, ewd);
            chk({tag, ".wbstable"}, LW'(stable), LW'(1));
            chk({tag, ".pcyc"}, LW'(pcyc), LW'(d + 1));
        end
        chk({tag, ".occ"}, LW'(occupancy), LW'(m_occ()));
        after_resp(tag);
    endtask

    task automatic do_reset();
        rst = 1; mem_read = 0; mem_write = 0; pmem_resp = 0;
        @(posedge clk); #1;
        rst = 0;
        m_reset();
    endtask

    initial begin
        logic [LW-1:0] rd, pw, b;
        logic [AW-1:0] pa;
        bit stable, h, ed;
        logic rdy;
        int lat, kind, pcyc;
        mem_address = '0; mem_wdata = '0; mem_dirty = 0; pmem_rdata = '0;
        do_reset();
        chk("rst.resp", LW'(mem_resp), LW'(0));
        chk("rst.pread", LW'(pmem_read), LW'(0));
        chk("rst.pwrite", LW'(pmem_write), LW'(0));
        chk("rst.occ", LW'(occupancy), LW'(0));
        chk("rst.rdata", mem_rdata, LW'(0));
        chk("rst.rdirty", LW'(mem_rdirty), LW'(0));
        chk("rst.paddr", LW'(pmem_address), LW'(0));
        chk("rst.pwdata", pmem_wdata, LW'(0));

        do_read(32'h1000, 3, "empty_read");
        do_write(32'h2000, rline(), 1, 0, "ins_dirty");
        do_read(32'h2000, 0, "hit_read");

        do_reset();
        for (int i = 0; i < E; i++) do_write(32'(i) << 8, rline(), 0, 0, "fill_clean");
        do_write(32'h800, rline(), 0, 2, "evict_clean");
        do_read(32'h000, 1, "evicted_miss");

        do_reset();
        do_write(32'h000, rline(), 1, 0, "fill_dirty0");
        for (int i = 1; i < E; i++) do_write(32'(i) << 8, rline(), 0, 0, "fill_rest");
        do_write(32'h800, rline(), 0, 5, "evict_dirty");
        do_read(32'h800, 0, "wb_then_hit");

        do_write(32'h300, rline(), 1, 0, "reins_dirty");
        do_write(32'h300, rline(), 0, 0, "reins_clean");
        do_read(32'h300, 0, "reins_read");

        do_reset();
        for (int i = 0; i < E; i++) do_write(32'(i) << 8, rline(), 1, 0, "fill_all_dirty");
        mem_write = 1; mem_address = 32'h900; mem_wdata = rline(); mem_dirty = 0;
        @(posedge clk); #1;
        chk("midwb.pwrite_on", LW'(pmem_write), LW'(1));
        @(posedge clk); #1;
        rst = 1; mem_write = 0;
        @(posedge clk); #1;
        rst = 0;
        m_reset();
        chk("midwb.pwrite_off", LW'(pmem_write), LW'(0));
        chk("midwb.occ", LW'(occupancy), LW'(0));
        do_read(32'h000, 0, "midwb_miss0");
        do_read(32'h900, 0, "midwb_miss9");

        do_write(32'h4000, rline(), 0, 0, "pre_both");
        b = rline();
        m_read(32'h5000, b, h, rd, ed);
        mem_read = 1; mem_write = 1; mem_address = 32'h5000; mem_wdata = rline(); mem_dirty = 1;
        wait_resp(1, b, lat, kind, pcyc, pa, pw, stable, rd, rdy);
        mem_read = 0;
        chk("both.read_lat", LW'(lat), LW'(3));
        chk("both.read_kind", LW'(kind), LW'(1));
        chk("both.read_data", rd, b);
        after_resp("both.read");
        m_insert(32'h5000, mem_wdata, 1, h, pa, pw);
        wait_resp(0, '0, lat, kind, pcyc, pa, pw, stable, rd, rdy);
        mem_write = 0;
        chk("both.write_lat", LW'(lat), LW'(1));
        chk("both.write_occ", LW'(occupancy), LW'(m_occ()));
        after_resp("both.write");
        do_read(32'h5000, 0, "both.readback");

        for (int n = 0; n < 200; n++) begin
            logic [AW-1:0] a;
            a = 32'($urandom_range(0, 11)) << 8;
            if ($urandom_range(0, 1) == 1) do_read(a, $urandom_range(0, 3), "rnd_read");
            else do_write(a, rline(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rnd_write");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
